// File: rtl/shift_issue_buffer_pkg.sv
// Shared types and constants for the shift issue buffer: the core
// configuration record, the decoded shifter request and the buffer states.
package shift_issue_buffer_pkg;

    // Subset of the core configuration consumed by the shift path.
    typedef struct packed {
        int unsigned XLEN;
        int unsigned LOG_XLEN;
        logic        ZBB_SUPPORTED;
    } cvw_t;

    localparam cvw_t CVW_RV64_ZBB   = '{XLEN: 64, LOG_XLEN: 6, ZBB_SUPPORTED: 1'b1};
    localparam cvw_t CVW_RV32_NOZBB = '{XLEN: 32, LOG_XLEN: 5, ZBB_SUPPORTED: 1'b0};

    // Request storage is sized for the widest configuration; narrower
    // configurations leave the upper bits at zero.
    localparam int unsigned MAX_XLEN     = 64;
    localparam int unsigned MAX_LOG_XLEN = 6;

    // Funct7[6:1] codes for the three legal shift families.
    localparam logic [5:0] SHF7_LOGIC = 6'b000000;
    localparam logic [5:0] SHF7_ARITH = 6'b010000;
    localparam logic [5:0] SHF7_ROT   = 6'b011000;

    typedef struct packed {
        logic [MAX_XLEN-1:0]     A;
        logic [MAX_LOG_XLEN-1:0] Amt;
        logic                    Right;
        logic                    Rotate;
        logic                    W64;
        logic                    SubArith;
        logic                    Illegal;
    } shift_req_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } buf_state_e;

endpackage

// File: rtl/shift_issue_buffer_decode.sv
// Combinational decode of funct fields into funnel-shifter controls, with
// detection of encodings that are not legal shifts/rotates on this core.
module shift_issue_buffer_decode
    import shift_issue_buffer_pkg::*;
#(
    parameter cvw_t P = CVW_RV64_ZBB
) (
    input  logic [2:0]            Funct3,
    input  logic [6:0]            Funct7,
    input  logic                  IsImm,
    input  logic                  OpW,
    input  logic [P.XLEN-1:0]     SrcA,
    input  logic [P.LOG_XLEN-1:0] AmtSrc,
    output shift_req_t            Req
);

    localparam logic IS_RV32 = (P.XLEN == 32);
    localparam logic IS_RV64 = (P.XLEN == 64);
    localparam logic HAS_ZBB = P.ZBB_SUPPORTED;

    logic [5:0] f7_hi;
    logic       right;
    logic       sub_arith;
    logic       rotate;
    logic       w64;
    logic       f3_ok;
    logic       f7_ok;

    // Field decode and legality; OpW only means something on RV64.
    always_comb begin
        f7_hi     = Funct7[6:1];
        right     = Funct3[2];
        sub_arith = (f7_hi == SHF7_ARITH);
        rotate    = (f7_hi == SHF7_ROT);
        w64       = IS_RV64 & OpW;
        f3_ok     = (Funct3 == 3'b001) | (Funct3 == 3'b101);
        f7_ok     = (f7_hi == SHF7_LOGIC) | sub_arith | rotate;

        Req                     = '0;
        Req.A[P.XLEN-1:0]       = SrcA;
        Req.Amt[P.LOG_XLEN-1:0] = AmtSrc;
        Req.Right               = right;
        Req.Rotate              = rotate;
        Req.W64                 = w64;
        Req.SubArith            = sub_arith;
        // imm[25] (Funct7[0]) is only a shamt bit for full-width RV64 shifts.
        Req.Illegal             = ~f3_ok
                                | ~f7_ok
                                | (sub_arith & ~right)
                                | (rotate & ~HAS_ZBB)
                                | (rotate & IsImm & ~right)
                                | (IsImm & Funct7[0] & (IS_RV32 | w64))
                                | (OpW & IS_RV32);
    end

endmodule

// File: rtl/shift_issue_buffer.sv
// Two-entry skid buffer in front of the funnel shifter. The Head entry drives
// the outputs; the Skid entry absorbs one request when the consumer stalls so
// InReady can be a plain register with no path from OutReady.
module shift_issue_buffer
    import shift_issue_buffer_pkg::*;
#(
    parameter cvw_t P = CVW_RV64_ZBB
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Flush,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [2:0]            Funct3,
    input  logic [6:0]            Funct7,
    input  logic                  IsImm,
    input  logic                  OpW,
    input  logic [P.XLEN-1:0]     SrcA,
    input  logic [P.XLEN-1:0]     SrcB,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [P.XLEN-1:0]     A,
    output logic [P.LOG_XLEN-1:0] Amt,
    output logic                  Right,
    output logic                  Rotate,
    output logic                  W64,
    output logic                  SubArith,
    output logic                  Illegal
);

    shift_req_t in_req;
    shift_req_t head_q, head_d;
    shift_req_t skid_q, skid_d;
    buf_state_e state_q, state_d;
    logic       out_valid_q;
    logic       in_ready_q;
    logic       accept;
    logic       pop;
    logic       unused_bits;

    shift_issue_buffer_decode #(
        .P(P)
    ) u_decode (
        .Funct3 (Funct3),
        .Funct7 (Funct7),
        .IsImm  (IsImm),
        .OpW    (OpW),
        .SrcA   (SrcA),
        .AmtSrc (SrcB[P.LOG_XLEN-1:0]),
        .Req    (in_req)
    );

    assign accept = InValid & in_ready_q;
    assign pop    = out_valid_q & OutReady;

    // Next state and entry movement; Flush overrides any accept or pop.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (Flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        head_d  = in_req;
                    end
                end
                ST_ONE: begin
                    if (accept && !pop) begin
                        state_d = ST_TWO;
                        skid_d  = in_req;
                    end else if (accept && pop) begin
                        head_d  = in_req;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // InReady is low here, so only a pop can happen.
                    if (pop) begin
                        state_d = ST_ONE;
                        head_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State, entries and registered handshake flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_TWO);
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = out_valid_q;
    assign A        = head_q.A[P.XLEN-1:0];
    assign Amt      = head_q.Amt[P.LOG_XLEN-1:0];
    assign Right    = head_q.Right;
    assign Rotate   = head_q.Rotate;
    assign W64      = head_q.W64;
    assign SubArith = head_q.SubArith;
    assign Illegal  = head_q.Illegal;

    // Upper SrcB bits and the padding of the widest-case entry are unused.
    assign unused_bits = ^{SrcB, head_q.A, head_q.Amt};

endmodule

// File: tb/tb_shift_issue_buffer.sv
// Directed bench for shift_issue_buffer: an RV64+Zbb instance (a_*) carries
// the handshake scenarios and an RV32 no-Zbb instance (b_*) the legality
// corner cases.
module tb_shift_issue_buffer;
    import shift_issue_buffer_pkg::*;

    localparam cvw_t CFG_A = CVW_RV64_ZBB;
    localparam cvw_t CFG_B = CVW_RV32_NOZBB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_flush, a_in_valid, a_in_ready, a_is_imm, a_opw;
    logic [2:0]  a_f3;
    logic [6:0]  a_f7;
    logic [63:0] a_src_a, a_src_b, a_a;
    logic        a_out_valid, a_out_ready;
    logic [5:0]  a_amt;
    logic        a_right, a_rotate, a_w64, a_sub, a_ill;

    logic        b_flush, b_in_valid, b_in_ready, b_is_imm, b_opw;
    logic [2:0]  b_f3;
    logic [6:0]  b_f7;
    logic [31:0] b_src_a, b_src_b, b_a;
    logic        b_out_valid, b_out_ready;
    logic [4:0]  b_amt;
    logic        b_right, b_rotate, b_w64, b_sub, b_ill;

    shift_issue_buffer #(.P(CFG_A)) dut_a (
        .clk(clk), .reset(reset), .Flush(a_flush),
        .InValid(a_in_valid), .InReady(a_in_ready),
        .Funct3(a_f3), .Funct7(a_f7), .IsImm(a_is_imm), .OpW(a_opw),
        .SrcA(a_src_a), .SrcB(a_src_b),
        .OutValid(a_out_valid), .OutReady(a_out_ready),
        .A(a_a), .Amt(a_amt), .Right(a_right), .Rotate(a_rotate),
        .W64(a_w64), .SubArith(a_sub), .Illegal(a_ill)
    );

    shift_issue_buffer #(.P(CFG_B)) dut_b (
        .clk(clk), .reset(reset), .Flush(b_flush),
        .InValid(b_in_valid), .InReady(b_in_ready),
        .Funct3(b_f3), .Funct7(b_f7), .IsImm(b_is_imm), .OpW(b_opw),
        .SrcA(b_src_a), .SrcB(b_src_b),
        .OutValid(b_out_valid), .OutReady(b_out_ready),
        .A(b_a), .Amt(b_amt), .Right(b_right), .Rotate(b_rotate),
        .W64(b_w64), .SubArith(b_sub), .Illegal(b_ill)
    );

    // Case vectors: {funct3, funct7, imm, opw, want_illegal, want_rotate}.
    localparam logic [13:0] ILL_A [5] = '{
        {3'b010, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0},  // funct3 010
        {3'b101, 7'b0110000, 1'b1, 1'b0, 1'b0, 1'b1},  // rori, legal with Zbb
        {3'b001, 7'b0110000, 1'b1, 1'b0, 1'b1, 1'b1},  // roli does not exist
        {3'b001, 7'b0100000, 1'b0, 1'b0, 1'b1, 1'b0},  // arithmetic left
        {3'b101, 7'b1000000, 1'b0, 1'b0, 1'b1, 1'b0}   // unknown funct7
    };
    localparam logic [13:0] ILL_B [4] = '{
        {3'b101, 7'b0110000, 1'b1, 1'b0, 1'b1, 1'b1},  // rori without Zbb
        {3'b001, 7'b0000001, 1'b1, 1'b0, 1'b1, 1'b0},  // slli imm[25] on RV32
        {3'b001, 7'b0000000, 1'b1, 1'b0, 1'b0, 1'b0},  // plain slli
        {3'b001, 7'b0000000, 1'b0, 1'b1, 1'b1, 1'b0}   // W op on RV32
    };

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                           input logic opw, input logic [63:0] sa, input logic [63:0] sb);
        a_f3 = f3; a_f7 = f7; a_is_imm = imm; a_opw = opw; a_src_a = sa; a_src_b = sb;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0;
        drive_a(3'b000, 7'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        b_flush = 0; b_in_valid = 0; b_out_ready = 1;
        b_f3 = 3'b000; b_f7 = 7'b0; b_is_imm = 0; b_opw = 0; b_src_a = '0; b_src_b = '0;
        step(); step(); step();
        checks++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_handshake got %b want 01", {a_out_valid, a_in_ready});
        end
        checks++;
        if ({a_a, a_amt, a_right, a_rotate, a_w64, a_sub, a_ill} !== '0) begin
            errors++; $display("FAIL reset_data got A=%h Amt=%0d want zeros", a_a, a_amt);
        end
        checks++;
        if ({b_out_valid, b_in_ready, b_ill} !== 3'b010) begin
            errors++; $display("FAIL reset_b got %b want 010", {b_out_valid, b_in_ready, b_ill});
        end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        a_out_ready = 1;
        drive_a(3'b101, 7'b0100000, 1'b1, 1'b0, 64'h8000_0000_0000_0010, 64'd4);
        a_in_valid = 1;
        step();
        a_in_valid = 0;
        checks++;
        if (a_out_valid !== 1'b1) begin
            errors++; $display("FAIL single_valid got %b want 1", a_out_valid);
        end
        checks++;
        if ({a_a, a_amt} !== {64'h8000_0000_0000_0010, 6'd4}) begin
            errors++; $display("FAIL single_data got A=%h Amt=%0d want 8000000000000010/4", a_a, a_amt);
        end
        checks++;
        if ({a_right, a_rotate, a_w64, a_sub, a_ill} !== 5'b10010) begin
            errors++; $display("FAIL single_ctl got %b want 10010", {a_right, a_rotate, a_w64, a_sub, a_ill});
        end
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain got %b want 0", a_out_valid);
        end
    endtask

    task automatic test_backpressure();
        a_out_ready = 0;
        drive_a(3'b001, 7'b0000000, 1'b1, 1'b0, 64'h11, 64'd1);
        a_in_valid = 1;
        step();
        checks++;
        if ({a_out_valid, a_in_ready} !== 2'b11) begin
            errors++; $display("FAIL bp_one got %b want 11", {a_out_valid, a_in_ready});
        end
        drive_a(3'b101, 7'b0000000, 1'b0, 1'b0, 64'h22, 64'd2);
        step();
        // Offered while full: must not be taken.
        drive_a(3'b101, 7'b0000000, 1'b0, 1'b0, 64'h33, 64'd3);
        step();
        a_in_valid = 0;
        checks++;
        if ({a_out_valid, a_in_ready} !== 2'b10) begin
            errors++; $display("FAIL bp_two got %b want 10", {a_out_valid, a_in_ready});
        end
        checks++;
        if ({a_a, a_amt, a_right} !== {64'h11, 6'd1, 1'b0}) begin
            errors++; $display("FAIL bp_head_r1 got A=%h Amt=%0d want 11/1", a_a, a_amt);
        end
        a_out_ready = 1;
        step();
        checks++;
        if ({a_out_valid, a_in_ready, a_a, a_amt, a_right} !== {2'b11, 64'h22, 6'd2, 1'b1}) begin
            errors++; $display("FAIL bp_head_r2 got V/R=%b%b A=%h Amt=%0d want 11/22/2",
                               a_out_valid, a_in_ready, a_a, a_amt);
        end
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain got %b want 0", a_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        a_out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            drive_a(3'b001, 7'b0000000, 1'b0, 1'b1, 64'h1000 + 64'(i),
                    64'hFFFF_0000_0000_0020 + 64'(i));
            a_in_valid = 1;
            step();
            checks++;
            if ({a_out_valid, a_in_ready, a_w64, a_ill} !== 4'b1110) begin
                errors++; $display("FAIL stream_ctl[%0d] got %b want 1110", i,
                                   {a_out_valid, a_in_ready, a_w64, a_ill});
            end
            checks++;
            if ({a_a, a_amt} !== {64'h1000 + 64'(i), 6'(32 + i)}) begin
                errors++; $display("FAIL stream_data[%0d] got A=%h Amt=%0d want %h/%0d", i,
                                   a_a, a_amt, 64'h1000 + 64'(i), 32 + i);
            end
        end
        a_in_valid = 0;
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_drain got %b want 0", a_out_valid);
        end
    endtask

    task automatic test_illegal();
        logic [13:0] v;
        a_out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            v = ILL_A[i];
            drive_a(v[13:11], v[10:4], v[3], v[2], 64'h5A, 64'd7);
            a_in_valid = 1;
            step();
            a_in_valid = 0;
            checks++;
            if ({a_out_valid, a_ill, a_rotate} !== {1'b1, v[1], v[0]}) begin
                errors++; $display("FAIL illegal_a[%0d] got V/Ill/Rot=%b want %b", i,
                                   {a_out_valid, a_ill, a_rotate}, {1'b1, v[1:0]});
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            v = ILL_B[i];
            b_f3 = v[13:11]; b_f7 = v[10:4]; b_is_imm = v[3]; b_opw = v[2];
            b_src_a = 32'hA5A5_0000 + 32'(i); b_src_b = 32'd9;
            b_in_valid = 1;
            step();
            b_in_valid = 0;
            checks++;
            if ({b_out_valid, b_ill, b_rotate, b_w64, b_amt} !== {1'b1, v[1], v[0], 1'b0, 5'd9}) begin
                errors++; $display("FAIL illegal_b[%0d] got V/Ill/Rot/W=%b Amt=%0d want %b/9", i,
                                   {b_out_valid, b_ill, b_rotate, b_w64}, b_amt, {1'b1, v[1:0], 1'b0});
            end
            step();
        end
    endtask

    task automatic test_flush();
        a_out_ready = 0;
        drive_a(3'b001, 7'b0000000, 1'b0, 1'b0, 64'h61, 64'd1);
        a_in_valid = 1;
        step();
        drive_a(3'b001, 7'b0000000, 1'b0, 1'b0, 64'h62, 64'd2);
        step();
        drive_a(3'b001, 7'b0000000, 1'b0, 1'b0, 64'h63, 64'd3);
        a_flush = 1;
        step();
        a_flush = 0; a_in_valid = 0;
        checks++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_two got %b want 01", {a_out_valid, a_in_ready});
        end
        a_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (a_out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_ghost[%0d] got valid %b A=%h want 0", i, a_out_valid, a_a);
            end
        end
        // Flush in ONE while a new request is also accepted.
        drive_a(3'b001, 7'b0000000, 1'b0, 1'b0, 64'h64, 64'd4);
        a_in_valid = 1;
        step();
        drive_a(3'b001, 7'b0000000, 1'b0, 1'b0, 64'h65, 64'd5);
        a_flush = 1;
        step();
        a_flush = 0; a_in_valid = 0;
        checks++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_accept got %b A=%h want 01", {a_out_valid, a_in_ready}, a_a);
        end
    endtask

    task automatic test_async_reset();
        a_out_ready = 1;
        drive_a(3'b001, 7'b0000000, 1'b0, 1'b0, 64'h71, 64'd1);
        a_in_valid = 1;
        step();
        a_in_valid = 0;
        checks++;
        if ({a_out_valid, a_a} !== {1'b1, 64'h71}) begin
            errors++; $display("FAIL areset_pre got V=%b A=%h want 1/71", a_out_valid, a_a);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({a_out_valid, a_in_ready, a_a} !== {2'b01, 64'h0}) begin
            errors++; $display("FAIL areset_now got V/R=%b%b A=%h want 01/0", a_out_valid, a_in_ready, a_a);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++; $display("FAIL areset_release got %b want 0", a_out_valid);
        end
        drive_a(3'b101, 7'b0000000, 1'b0, 1'b0, 64'h75, 64'd3);
        a_in_valid = 1;
        step();
        a_in_valid = 0;
        checks++;
        if ({a_out_valid, a_a, a_amt, a_right, a_ill} !== {1'b1, 64'h75, 6'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL areset_first got V=%b A=%h Amt=%0d want 1/75/3", a_out_valid, a_a, a_amt);
        end
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++; $display("FAIL areset_drain got %b want 0", a_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_issue_buffer.md
Name: shift_issue_buffer

Overview:
- Pipeline stage directly upstream of the IEU funnel shifter.
- Accepts decoded shift/rotate requests over a valid/ready handshake and decodes the funct fields into the shifter controls: Right, Rotate, W64, SubArith and Amt.
- Holds requests in a 2-entry skid buffer so that downstream backpressure never creates a combinational ready path upstream.
- Supports pipeline flush and flags illegal encodings.

Parameters:
- P: cvw_t configuration, no default. Supplies XLEN (32/64), LOG_XLEN and ZBB_SUPPORTED.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- Flush  in  1  discard all held and incoming requests.
- InValid  in  1  upstream request valid.
- InReady  out  1  buffer can accept; registered.
- Funct3  in  3  001 = left class, 101 = right class.
- Funct7  in  7  bits [6:1]: 000000 logical, 010000 arithmetic, 011000 rotate. Bit 0 is imm[25].
- IsImm  in  1  immediate form (slli/srli/srai/rori).
- OpW  in  1  W-type operation (RV64 only; ignored on RV32).
- SrcA  in  XLEN  shift source.
- SrcB  in  XLEN  rs2 or sign-extended immediate.
- OutValid  out  1  head entry valid.
- OutReady  in  1  downstream accepts head.
- A  out  XLEN  head source operand.
- Amt  out  LOG_XLEN  head shift amount.
- Right, Rotate, W64, SubArith  out  1 each  head shifter controls.
- Illegal  out  1  head entry is an illegal encoding.

Behaviour:
- Decode is combinational on the inputs and captured on accept.
  - Right = Funct3[2].
  - SubArith = (Funct7[6:1] == 010000).
  - Rotate = (Funct7[6:1] == 011000).
  - W64 = OpW when XLEN = 64, else 0.
  - Amt = SrcB[LOG_XLEN-1:0].
- Illegal is set when any of the following holds:
  - Funct3 is not 001 or 101.
  - Funct7[6:1] is not one of the three legal codes.
  - SubArith is set with Right = 0.
  - Rotate is set with ZBB_SUPPORTED = 0.
  - rol/ror with IsImm and Right = 0 (no roli).
  - IsImm with Funct7[0] = 1 and (XLEN = 32 or W64).
  - OpW = 1 on XLEN = 32.
- Illegal entries flow through the buffer normally; consumers squash them.
- Storage: a Head register (drives the outputs) and a Skid register, each with a valid bit.
- States:
  - EMPTY: no valid entry.
  - ONE: Head valid.
  - TWO: Head and Skid valid.
- Handshake:
  - accept = InValid & InReady.
  - pop = OutValid & OutReady.
  - InReady = ~SkidValid, registered (state != TWO).
- Transitions (Flush = 0):
  - EMPTY: accept → ONE, request loaded into Head.
  - ONE, accept & ~pop → TWO, request loaded into Skid.
  - ONE, accept & pop → stay ONE, Head reloaded with the new request.
  - ONE, ~accept & pop → EMPTY.
  - TWO, pop → ONE, Skid moves to Head. No accept is possible in TWO.
  - Any other case holds state.
- Latency: accept at edge N → OutValid at edge N+1. Throughput is 1 per cycle while OutReady = 1.
- Ordering is strict FIFO. The entry in Skid is always younger than the entry in Head.
- Flush = 1: next edge goes to EMPTY and drops any concurrent accept. Flush has priority over accept and pop. A pop in the flush cycle still counts as delivered.
- OutReady may rise or fall in any cycle.
- A and the controls are stable while OutValid = 1 & OutReady = 0.
- Reset (reset = 0, asynchronous): state EMPTY, OutValid = 0, InReady = 1, all data/control registers 0, Illegal = 0. Reset asserted mid-transfer loses all entries without any output glitch to valid. Release is synchronised by the existing reset synchroniser.

Decomposition:
- Package cvw (existing): add typedef shift_req_t = {A, Amt, Right, Rotate, W64, SubArith, Illegal}.
- Package cvw: add localparams SHF7_LOGIC = 6'b000000, SHF7_ARITH = 6'b010000, SHF7_ROT = 6'b011000.
- One sub-module shift_decode: combinational decode to shift_req_t. This module is the register/FSM wrapper around it.
- The existing flop primitives (flopenr style) are reused with the active-low async reset.

Test Plan:
- Reset then single request: XLEN = 64, srai, SrcA = 0x8000_0000_0000_0010, SrcB = 4, OutReady = 1 → one cycle later OutValid = 1, Right = 1, SubArith = 1, Rotate = 0, W64 = 0, Amt = 4, Illegal = 0.
- Backpressure: OutReady = 0, accept requests R1 then R2 → state TWO, InReady = 0, Head = R1. Raise OutReady for 2 cycles → R1 then R2 delivered in order, InReady = 1 after the first pop.
- Streaming: 8 back-to-back sllw requests with OutReady = 1 → 8 pops on consecutive cycles, W64 = 1, Amt[5] preserved as in SrcB, no bubbles.
- Illegal cases: rori with ZBB_SUPPORTED = 0 → Illegal = 1. XLEN = 32 slli with Funct7[0] = 1 → Illegal = 1. Funct3 = 010 → Illegal = 1.
- Flush in TWO concurrent with InValid → next cycle OutValid = 0, InReady = 1, and the flushed requests never appear.
- Async reset asserted mid-stream between clock edges → OutValid = 0 immediately. After release, the first accepted request appears correctly with latency 1.
